pio_fifo_reader: RTL and testbench

//  Bridges the FPGA sample FIFO (read side) to the HPS PIO handshake registers in soc_system.
//  The HPS toggles one PIO bit per word request; this block pops one DATA_W word from the FIFO,

---
 rtl/pio_fifo_reader_pkg.sv | 22 ++
 rtl/pio_fifo_reader_toggle_edge_det.sv | 25 ++
 rtl/pio_fifo_reader.sv | 216 +++++++++++++++++++++
 tb/tb_pio_fifo_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_fifo_reader_pkg.sv
// rtl/pio_fifo_reader_pkg.sv - shared state type and bit indices for pio_fifo_reader
package pio_fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        ACK  = 2'd3
    } rd_state_t;

    localparam int ST_ACK   = 0;
    localparam int ST_VALID = 1;
    localparam int ST_UFLOW = 2;
    localparam int ST_OVR   = 3;
    localparam int ST_WRF   = 4;
    localparam int ST_BUSY  = 5;

    localparam int RQ_EN         = 0;
    localparam int RQ_CLR_STICKY = 1;
    localparam int RQ_CLR_CNT    = 2;

endpackage

// File: rtl/pio_fifo_reader_toggle_edge_det.sv
// rtl/pio_fifo_reader_toggle_edge_det.sv - toggle edge detector that arms one cycle after reset
module toggle_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic i_tgl,
    output logic o_edge
);

    logic r_armed;
    logic r_prev;

    // Track the toggle level; the first cycle out of reset only loads it so a level held through reset is not a request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_prev  <= i_tgl;
        end
    end

    assign o_edge = r_armed & (i_tgl ^ r_prev);

endmodule

// File: rtl/pio_fifo_reader.sv
// rtl/pio_fifo_reader.sv - FIFO read side to HPS PIO word/ack handshake (optional prefetch: PIO_FIFO_READER_PREFETCH_EN)
module pio_fifo_reader
    import pio_fifo_reader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_clk_tgl,
    input  logic [7:0]        read_rq,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    input  logic              fifo_wrfull,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] word_out,
    output logic [7:0]        read_status,
    output logic [CNT_W-1:0]  word_count
);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic              r_pending;
    logic              r_ack;
    logic              r_valid;
    logic              r_uflow;
    logic              r_ovr;
    logic              r_wrf;
    logic [DATA_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;

    logic              w_edge;
    logic              w_accept;
    logic              w_fsm_rdreq;
    logic              w_pend_clr;
    logic              w_serve;
    logic              w_inc;
    logic              w_uflow_set;
    logic              w_ack_tgl;
    logic              w_clr_sticky;
    logic              w_clr_cnt;
    logic              w_pf_hit;
    logic              w_pf_wait;
    logic [DATA_W-1:0] w_pf_data;
    logic              w_unused_rq;

    assign w_unused_rq  = ^read_rq[7:3];
    assign w_clr_sticky = read_rq[RQ_CLR_STICKY];
    assign w_clr_cnt    = read_rq[RQ_CLR_CNT];

    toggle_edge_det u_edge_det (
        .clk     (clk),
        .reset_n (reset_n),
        .i_tgl   (read_clk_tgl),
        .o_edge  (w_edge)
    );

    // Edges keep being tracked while disabled; they just never become requests
    assign w_accept = w_edge & read_rq[RQ_EN];

`ifdef PIO_FIFO_READER_PREFETCH_EN
    logic              r_pf_valid;
    logic              r_pf_fill;
    logic [DATA_W-1:0] r_pf_data;
    logic              w_pf_req;

    // Refill only from an idle, request-free cycle so it never competes with the FSM pop
    assign w_pf_req = (r_state == IDLE) && !r_pending && !r_pf_valid && !r_pf_fill
                      && !fifo_empty && read_rq[RQ_EN];

    // Stage one word ahead; data lands the cycle after the pop strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pf_valid <= 1'b0;
            r_pf_fill  <= 1'b0;
            r_pf_data  <= '0;
        end else begin
            r_pf_fill <= w_pf_req;
            if (r_pf_fill) begin
                r_pf_valid <= 1'b1;
                r_pf_data  <= fifo_q;
            end else if (w_serve) begin
                r_pf_valid <= 1'b0;
            end
        end
    end

    assign w_pf_hit   = r_pf_valid;
    assign w_pf_wait  = r_pf_fill;
    assign w_pf_data  = r_pf_data;
    assign fifo_rdreq = w_fsm_rdreq | w_pf_req;
`else
    assign w_pf_hit   = 1'b0;
    assign w_pf_wait  = 1'b0;
    assign w_pf_data  = '0;
    assign fifo_rdreq = w_fsm_rdreq;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle strobes; a popped word acks on leaving CAPT, an underflow acks on leaving ACK
    always_comb begin
        w_next      = r_state;
        w_fsm_rdreq = 1'b0;
        w_pend_clr  = 1'b0;
        w_serve     = 1'b0;
        w_inc       = 1'b0;
        w_uflow_set = 1'b0;
        w_ack_tgl   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    if (w_pf_hit) begin
                        w_serve    = 1'b1;
                        w_inc      = 1'b1;
                        w_ack_tgl  = 1'b1;
                        w_pend_clr = 1'b1;
                    end else if (w_pf_wait) begin
                        w_next = IDLE;
                    end else if (fifo_empty) begin
                        w_uflow_set = 1'b1;
                        w_next      = ACK;
                    end else begin
                        w_next = POP;
                    end
                end
            end
            POP: begin
                w_fsm_rdreq = 1'b1;
                w_next      = CAPT;
            end
            CAPT: begin
                w_inc     = 1'b1;
                w_ack_tgl = 1'b1;
                w_next    = ACK;
            end
            ACK: begin
                // valid is low here only when this request took the empty path
                w_ack_tgl  = !r_valid;
                w_pend_clr = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request bookkeeping, captured word, handshake bits, sticky flags and pop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_valid   <= 1'b0;
            r_uflow   <= 1'b0;
            r_ovr     <= 1'b0;
            r_wrf     <= 1'b0;
            r_word    <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept && (w_pend_clr || !r_pending)) begin
                r_pending <= 1'b1;
            end else if (w_pend_clr) begin
                r_pending <= 1'b0;
            end

            if (w_ack_tgl) begin
                r_ack <= ~r_ack;
            end

            if ((r_state == CAPT) || w_serve) begin
                r_valid <= 1'b1;
            end else if (w_uflow_set) begin
                r_valid <= 1'b0;
            end

            if (r_state == CAPT) begin
                r_word <= fifo_q;
            end else if (w_serve) begin
                r_word <= w_pf_data;
            end

            if (w_clr_sticky) begin
                r_uflow <= 1'b0;
                r_ovr   <= 1'b0;
                r_wrf   <= 1'b0;
            end else begin
                if (w_uflow_set) begin
                    r_uflow <= 1'b1;
                end
                if (w_accept && r_pending && !w_pend_clr) begin
                    r_ovr <= 1'b1;
                end
                if (fifo_wrfull) begin
                    r_wrf <= 1'b1;
                end
            end

            if (w_clr_cnt) begin
                r_count <= '0;
            end else if (w_inc) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign word_out    = r_word;
    assign word_count  = r_count;
    assign read_status = {2'b00, (r_state != IDLE) | r_pending, r_wrf, r_ovr, r_uflow, r_valid, r_ack};

endmodule

// File: tb/tb_pio_fifo_reader.sv
// tb/tb_pio_fifo_reader.sv - self-checking bench for pio_fifo_reader with a FIFO model and request-level reference
module tb_pio_fifo_reader;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              read_clk_tgl = 1'b0;
    logic [7:0]        read_rq = 8'h00;
    logic [DATA_W-1:0] fifo_q = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_wrfull = 1'b0;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] word_out;
    logic [7:0]        read_status;
    logic [CNT_W-1:0]  word_count;

    pio_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_clk_tgl (read_clk_tgl),
        .read_rq      (read_rq),
        .fifo_q       (fifo_q),
        .fifo_empty   (fifo_empty),
        .fifo_wrfull  (fifo_wrfull),
        .fifo_rdreq   (fifo_rdreq),
        .word_out     (word_out),
        .read_status  (read_status),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] mq[$];
    int rd_pulses = 0;
    int rd_run = 0;
    int rd_max_run = 0;

    always @(posedge clk) begin
        if (fifo_rdreq) begin
            rd_pulses++;
            rd_run++;
            if (rd_run > rd_max_run) rd_max_run = rd_run;
            if (fq.size() > 0) fifo_q <= fq.pop_front();
        end else begin
            rd_run = 0;
        end
    end

    always @(negedge clk) fifo_empty = (fq.size() == 0);

    int n_tests = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_word = '0;
    int  exp_count = 0;
    int  exp_acks = 0;
    bit  exp_valid = 0;
    bit  exp_uflow = 0;
    bit  exp_ovr = 0;
    bit  exp_wrf = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        mq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic model_reset();
        exp_word = '0; exp_count = 0; exp_acks = 0;
        exp_valid = 0; exp_uflow = 0; exp_ovr = 0; exp_wrf = 0;
    endtask

    // One request: a word if the FIFO holds one, otherwise an underflow ack; latency counted in
    // negedges from the toggle, so it is one more than the count from the registering clock edge.
    task automatic request(input string tag);
        int   lat;
        int   rd0;
        logic a0;
        bit   exp_pop;
        exp_pop = (mq.size() != 0);
        a0  = read_status[0];
        rd0 = rd_pulses;
        read_clk_tgl = ~read_clk_tgl;
        lat = 0;
        while (read_status[0] === a0 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        exp_acks++;
        if (exp_pop) begin
            exp_word  = mq.pop_front();
            exp_valid = 1;
            exp_count++;
        end else begin
            exp_valid = 0;
            exp_uflow = 1;
        end
        if (read_rq[2]) exp_count = 0;
        if (read_rq[1]) begin exp_uflow = 0; exp_ovr = 0; exp_wrf = 0; end
        chk({tag, "_latency"}, lat, exp_pop ? 4 : 3);
        chk({tag, "_word"}, word_out, exp_word);
        chk({tag, "_valid"}, read_status[1], exp_valid);
        chk({tag, "_count"}, word_count, exp_count % CNT_MOD);
        chk({tag, "_ack"}, read_status[0], exp_acks % 2);
        @(negedge clk);
        chk({tag, "_busy"}, read_status[5], 0);
        chk({tag, "_sticky"}, read_status[4:2], {exp_wrf, exp_ovr, exp_uflow});
        chk({tag, "_rdreqs"}, rd_pulses - rd0, exp_pop);
    endtask

    initial begin
        int rd0;
        int need;

        step(3);
        reset_n = 1'b1;
        step(1);
        chk("rst_status", read_status, 8'h00);
        chk("rst_word", word_out, 0);
        chk("rst_count", word_count, 0);
        chk("rst_rdreq", fifo_rdreq, 0);

        // Disabled: edge ignored
        push(16'h5A5A);
        rd0 = rd_pulses;
        read_clk_tgl = ~read_clk_tgl;
        step(6);
        chk("dis_status", read_status, 8'h00);
        chk("dis_rdreqs", rd_pulses - rd0, 0);

        read_rq = 8'h01;
        request("drain_pre");

        push(16'h1234);
        push(16'hABCD);
        request("pop_1234");
        step(10);
        request("pop_abcd");
        request("empty");

        for (int i = 0; i < 10; i++) begin
            int n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) push(DATA_W'($urandom_range(0, 65535)));
            step($urandom_range(0, 3));
            request("rand");
        end

        // Overrun: second toggle one cycle into a busy request is dropped
        read_rq = 8'h03;
        step(1);
        read_rq = 8'h01;
        exp_uflow = 0; exp_ovr = 0; exp_wrf = 0;
        while (mq.size() > 0) request("drain_a");
        push(DATA_W'($urandom_range(0, 65535)));
        push(DATA_W'($urandom_range(0, 65535)));
        rd0 = rd_pulses;
        read_clk_tgl = ~read_clk_tgl;
        step(1);
        read_clk_tgl = ~read_clk_tgl;
        step(8);
        exp_acks++;
        exp_word = mq.pop_front();
        exp_count++;
        exp_valid = 1;
        exp_ovr = 1;
        chk("ovr_flag", read_status[3], 1);
        chk("ovr_ack", read_status[0], exp_acks % 2);
        chk("ovr_word", word_out, exp_word);
        chk("ovr_rdreqs", rd_pulses - rd0, 1);
        request("ovr_third");
        chk("ovr_total_rdreqs", rd_pulses - rd0, 2);

        // Write-full sticky, then clear racing a new underflow
        fifo_wrfull = 1'b1;
        step(1);
        fifo_wrfull = 1'b0;
        exp_wrf = 1;
        step(1);
        chk("wrf_flag", read_status[4], 1);
        read_rq = 8'h03;
        request("clr_uflow");
        read_rq = 8'h01;
        step(2);
        chk("clr_sticky_after", read_status[4:2], 0);

        // Counter wrap at 2^CNT_W
        need = (CNT_MOD - 1) - (exp_count % CNT_MOD);
        for (int i = 0; i <= need; i++) push(DATA_W'($urandom_range(0, 65535)));
        for (int i = 0; i < need; i++) request("to_max");
        chk("cnt_max", word_count, CNT_MOD - 1);
        request("cnt_wrap");
        chk("cnt_wrapped", word_count, 0);
        push(16'h0F0F);
        request("cnt_one");
        push(16'hF0F0);
        read_rq = 8'h05;
        request("cnt_clr_pop");
        read_rq = 8'h01;
        step(1);
        chk("cnt_after_clr", word_count, 0);

        // Toggle level held through reset release is not a request
        reset_n = 1'b0;
        read_clk_tgl = 1'b1;
        model_reset();
        step(2);
        reset_n = 1'b1;
        push(16'h7777);
        rd0 = rd_pulses;
        step(8);
        chk("tglhold_status", read_status, 8'h00);
        chk("tglhold_rdreqs", rd_pulses - rd0, 0);

        // Reset asserted during POP
        read_clk_tgl = ~read_clk_tgl;
        step(2);
        chk("midpop_rdreq_hi", fifo_rdreq, 1);
        reset_n = 1'b0;
        #1;
        chk("midpop_rdreq_lo", fifo_rdreq, 0);
        step(2);
        reset_n = 1'b1;
        model_reset();
        rd0 = rd_pulses;
        step(6);
        chk("midpop_status", read_status, 8'h00);
        chk("midpop_word", word_out, 0);
        chk("midpop_rdreqs", rd_pulses - rd0, 0);
        request("post_reset");

        chk("rdreq_width", rd_max_run, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
